// File: rtl/sr_pkg.sv
// Shared encodings and next-state helpers for the SR storage cells.
package sr_pkg;

   // {s,r} request encodings
   localparam logic [1:0] SR_HOLD     = 2'b00;
   localparam logic [1:0] SR_RESET    = 2'b01;
   localparam logic [1:0] SR_SET      = 2'b10;
   localparam logic [1:0] SR_CONFLICT = 2'b11;

   // Next stored bit given the current bit and the sampled requests.
   // A simultaneous set and reset keeps the stored value.
   function automatic logic sr_next(input logic q, input logic s,
                                    input logic r, input logic en);
      logic nxt;
      nxt = q;
      if (en) begin
         case ({s, r})
            SR_SET:      nxt = 1'b1;
            SR_RESET:    nxt = 1'b0;
            SR_HOLD:     nxt = q;
            SR_CONFLICT: nxt = q;
            default:     nxt = q;
         endcase
      end
      return nxt;
   endfunction

   // Conflict flag for one edge: both requests asserted while enabled.
   function automatic logic sr_conflict(input logic s, input logic r,
                                        input logic en);
      return en && ({s, r} == SR_CONFLICT);
   endfunction

endpackage

// File: rtl/sr_cell.sv
// One registered set/reset bit with a one-cycle conflict pulse.
module sr_cell
   import sr_pkg::*;
#(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic s,
   input  logic r,
   output logic q,
   output logic qn,
   output logic conflict
);

   logic q_p0;
   logic conflict_p0;

   // Stored bit and conflict flag, both updated on the rising edge; reset wins
   always_ff @(posedge clk) begin
      if (rst) begin
         q_p0        <= RESET_VAL;
         conflict_p0 <= 1'b0;
      end else begin
         q_p0        <= sr_next(q_p0, s, r, en);
         conflict_p0 <= sr_conflict(s, r, en);
      end
   end

   // qn is derived from the same flop so it can never disagree with q
   assign q        = q_p0;
   assign qn       = ~q_p0;
   assign conflict = conflict_p0;

endmodule

// File: rtl/sr_latch.sv
// WIDTH independent clock-synchronous SR bits used as sticky status flags.
module sr_latch
   import sr_pkg::*;
#(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic [WIDTH-1:0] conflict
);

   // Bits share only clk/rst/en; each bit's state and flag are independent
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sr_cell #(
         .RESET_VAL (RESET_VAL[i])
      ) u_cell (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .s        (s[i]),
         .r        (r[i]),
         .q        (q[i]),
         .qn       (qn[i]),
         .conflict (conflict[i])
      );
   end

endmodule

// File: tb/tb_sr_latch.sv
module tb_sr_latch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // scalar instance
   logic rst_a = 1'b1, en_a = 1'b0, s_a = 1'b0, r_a = 1'b0;
   logic q_a, qn_a, c_a;
   // 8-bit instance
   logic       rst_b = 1'b1, en_b = 1'b0;
   logic [7:0] s_b = '0, r_b = '0;
   logic [7:0] q_b, qn_b, c_b;

   sr_latch #(.WIDTH(1), .RESET_VAL(1'b0)) dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .s(s_a), .r(r_a),
      .q(q_a), .qn(qn_a), .conflict(c_a)
   );

   sr_latch #(.WIDTH(8), .RESET_VAL(8'hA5)) dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .s(s_b), .r(r_b),
      .q(q_b), .qn(qn_b), .conflict(c_b)
   );

   typedef struct {
      logic [7:0] q;
      logic [7:0] c;
      string      tag;
   } exp_t;

   exp_t sb_a[$];
   exp_t sb_b[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_check_a();
      exp_t e;
      e = sb_a.pop_front();
      chk({e.tag, ".q"},        {7'b0, q_a},  e.q);
      chk({e.tag, ".qn"},       {7'b0, qn_a}, {7'b0, ~e.q[0]});
      chk({e.tag, ".conflict"}, {7'b0, c_a},  e.c);
   endtask

   task automatic pop_check_b();
      exp_t e;
      e = sb_b.pop_front();
      chk({e.tag, ".q"},        q_b,  e.q);
      chk({e.tag, ".qn"},       qn_b, ~e.q);
      chk({e.tag, ".conflict"}, c_b,  e.c);
   endtask

   // directed step on the scalar instance with explicit expected results
   task automatic step_a(input logic rst, input logic en, input logic s, input logic r,
                         input logic eq, input logic ec, input string tag);
      exp_t e;
      @(negedge clk);
      rst_a = rst; en_a = en; s_a = s; r_a = r;
      e.q = {7'b0, eq}; e.c = {7'b0, ec}; e.tag = tag;
      sb_a.push_back(e);
      @(posedge clk); #1;
      pop_check_a();
   endtask

   task automatic step_b(input logic rst, input logic en, input logic [7:0] s,
                         input logic [7:0] r, input logic [7:0] eq,
                         input logic [7:0] ec, input string tag);
      exp_t e;
      @(negedge clk);
      rst_b = rst; en_b = en; s_b = s; r_b = r;
      e.q = eq; e.c = ec; e.tag = tag;
      sb_b.push_back(e);
      @(posedge clk); #1;
      pop_check_b();
   endtask

   // independent reference: set dominates only when reset is absent, s=r=1 keeps q
   function automatic logic [7:0] ref_q(input logic [7:0] q, input logic rst,
                                        input logic [7:0] rv, input logic en,
                                        input logic [7:0] s, input logic [7:0] r);
      if (rst) return rv;
      if (!en) return q;
      return (s & ~r) | (q & ~(s ^ r));
   endfunction

   function automatic logic [7:0] ref_c(input logic rst, input logic en,
                                        input logic [7:0] s, input logic [7:0] r);
      if (rst || !en) return 8'h00;
      return s & r;
   endfunction

   initial begin
      logic [7:0] mqa, mqb;
      exp_t       ea, eb;

      // reset held two edges with set requested
      step_a(1, 1, 1, 0, 0, 0, "reset_edge1");
      step_a(1, 1, 1, 0, 0, 0, "reset_edge2");

      // enabled request sequence from q=0
      step_a(0, 1, 1, 0, 1, 0, "seq_set");
      step_a(0, 1, 0, 1, 0, 0, "seq_reset");
      step_a(0, 1, 0, 0, 0, 0, "seq_hold0");
      step_a(0, 1, 1, 1, 0, 1, "seq_conflict0");
      step_a(0, 1, 0, 0, 0, 0, "seq_after_conflict0");

      // same from q=1
      step_a(0, 1, 1, 0, 1, 0, "seq1_set");
      step_a(0, 1, 0, 0, 1, 0, "seq1_hold");
      step_a(0, 1, 1, 1, 1, 1, "seq1_conflict");
      step_a(0, 1, 1, 0, 1, 0, "seq1_reset_while_set");

      // enable gating
      step_a(0, 0, 0, 1, 1, 0, "gate_1");
      step_a(0, 0, 0, 1, 1, 0, "gate_2");
      step_a(0, 0, 1, 1, 1, 0, "gate_conflict_masked");
      step_a(0, 1, 0, 1, 0, 0, "gate_release");
      step_a(0, 1, 0, 1, 0, 0, "reset_while_clear");

      // reset priority over a simultaneous set
      step_a(0, 1, 1, 0, 1, 0, "prio_set");
      step_a(1, 1, 1, 0, 0, 0, "prio_reset");
      step_a(0, 1, 1, 0, 1, 0, "prio_release");

      // multi-bit instance
      step_b(1, 1, 8'hFF, 8'h00, 8'hA5, 8'h00, "mb_reset");
      step_b(0, 1, 8'h0F, 8'hF0, 8'h0F, 8'h00, "mb_split");
      step_b(0, 1, 8'hFF, 8'hFF, 8'h0F, 8'hFF, "mb_conflict");
      step_b(0, 1, 8'h00, 8'h00, 8'h0F, 8'h00, "mb_pulse_clears");
      step_b(0, 1, 8'h30, 8'h30, 8'h0F, 8'h30, "mb_partial_conflict");
      step_b(0, 1, 8'h80, 8'h01, 8'h8E, 8'h00, "mb_independent");

      // randomized run on both instances against the reference model
      mqa = 8'h00;
      mqb = 8'h00;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         rst_a = (i == 0) || ($urandom_range(0, 49) == 0);
         en_a  = $urandom_range(0, 3) != 0;
         s_a   = 1'($urandom);
         r_a   = 1'($urandom);
         rst_b = (i == 0) || ($urandom_range(0, 49) == 0);
         en_b  = $urandom_range(0, 3) != 0;
         s_b   = 8'($urandom);
         r_b   = 8'($urandom);
         ea.c  = ref_c(rst_a, en_a, {7'b0, s_a}, {7'b0, r_a});
         mqa   = ref_q(mqa, rst_a, 8'h00, en_a, {7'b0, s_a}, {7'b0, r_a}) & 8'h01;
         ea.q  = mqa;
         ea.tag = "rand_a";
         sb_a.push_back(ea);
         eb.c  = ref_c(rst_b, en_b, s_b, r_b);
         mqb   = ref_q(mqb, rst_b, 8'hA5, en_b, s_b, r_b);
         eb.q  = mqb;
         eb.tag = "rand_b";
         sb_b.push_back(eb);
         @(posedge clk); #1;
         pop_check_a();
         pop_check_b();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
